// File: rtl/rs_complex_if.sv
// Bundle of dispatch, writeback, issue and entry-packet signals between
// the complex reservation station and its neighbouring pipeline stages.
interface rs_complex_if #(
   parameter int ENTRY_W = 114,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
);
   logic               flush;
   logic               dispatch_valid;
   logic               dispatch_ready;
   logic [ENTRY_W-1:0] dispatch_inst;
   logic [TAG_W-1:0]   dispatch_rob_num;
   logic               wb0_valid;
   logic [TAG_W-1:0]   wb0_rob_num;
   logic [DATA_W-1:0]  wb0_data;
   logic               wb1_valid;
   logic [TAG_W-1:0]   wb1_rob_num;
   logic [DATA_W-1:0]  wb1_data;
   logic [ENTRY_W-1:0] rs_complex_0;
   logic [ENTRY_W-1:0] rs_complex_1;
   logic [TAG_W-1:0]   rs_complex_0_entry_num;
   logic [TAG_W-1:0]   rs_complex_1_entry_num;
   logic               selector;
   logic               complex_0_issue;
   logic               complex_1_issue;

   modport master (
      output flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
      output wb0_valid, wb0_rob_num, wb0_data,
      output wb1_valid, wb1_rob_num, wb1_data,
      output complex_0_issue, complex_1_issue,
      input  dispatch_ready, rs_complex_0, rs_complex_1,
      input  rs_complex_0_entry_num, rs_complex_1_entry_num, selector
   );

   modport slave (
      input  flush, dispatch_valid, dispatch_inst, dispatch_rob_num,
      input  wb0_valid, wb0_rob_num, wb0_data,
      input  wb1_valid, wb1_rob_num, wb1_data,
      input  complex_0_issue, complex_1_issue,
      output dispatch_ready, rs_complex_0, rs_complex_1,
      output rs_complex_0_entry_num, rs_complex_1_entry_num, selector
   );
endinterface

// File: rtl/rs_complex_station.sv
// Two-entry reservation station for the complex unit: holds dispatched
// instructions, captures operands from two writeback buses, clears on issue.
module rs_complex_station #(
   parameter int ENTRY_W = 114,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
) (
   input logic         clk,
   input logic         rst,
   rs_complex_if.slave bus
);
   // An operand field is {value, ready}; rs1 starts at bit 5, rs2 at bit 38.
   localparam int RS1_LO = 5;
   localparam int RS2_LO = 38;
   localparam int OP_W   = DATA_W + 1;

   logic [1:0]         valid_reg;
   logic [1:0]         valid_next;
   logic [ENTRY_W-1:0] pkt_reg  [2];
   logic [ENTRY_W-1:0] pkt_next [2];
   logic [TAG_W-1:0]   tag_reg  [2];
   logic [TAG_W-1:0]   tag_next [2];
   logic               selector_reg;
   logic               selector_next;

   logic [1:0]         issue;
   logic [1:0]         free;
   logic [1:0]         hit;
   logic [1:0]         remain;
   logic               accept;
   logic               target;
   logic [ENTRY_W-1:0] disp_pkt;

   function automatic logic [OP_W-1:0] wake_op(
      input logic [OP_W-1:0]   op,
      input logic              v0,
      input logic [TAG_W-1:0]  t0,
      input logic [DATA_W-1:0] d0,
      input logic              v1,
      input logic [TAG_W-1:0]  t1,
      input logic [DATA_W-1:0] d1
   );
      logic [OP_W-1:0] res;
      res = op;
      if (!op[0]) begin
         if (v0 && (t0 == op[TAG_W:1])) begin
            res = {d0, 1'b1};
         end else if (v1 && (t1 == op[TAG_W:1])) begin
            res = {d1, 1'b1};
         end
      end
      return res;
   endfunction

   function automatic logic [ENTRY_W-1:0] wake_pkt(
      input logic [ENTRY_W-1:0] p,
      input logic               v0,
      input logic [TAG_W-1:0]   t0,
      input logic [DATA_W-1:0]  d0,
      input logic               v1,
      input logic [TAG_W-1:0]   t1,
      input logic [DATA_W-1:0]  d1
   );
      logic [ENTRY_W-1:0] res;
      res = p;
      res[RS1_LO +: OP_W] = wake_op(p[RS1_LO +: OP_W], v0, t0, d0, v1, t1, d1);
      res[RS2_LO +: OP_W] = wake_op(p[RS2_LO +: OP_W], v0, t0, d0, v1, t1, d1);
      return res;
   endfunction

   // A waiting operand keeps only its producer tag; the rest of the value is zeroed.
   function automatic logic [OP_W-1:0] clean_op(input logic [OP_W-1:0] op);
      logic [OP_W-1:0] res;
      res = op;
      if (!op[0]) begin
         res = {{(DATA_W-TAG_W){1'b0}}, op[TAG_W:0]};
      end
      return res;
   endfunction

   function automatic logic [ENTRY_W-1:0] clean_pkt(input logic [ENTRY_W-1:0] p);
      logic [ENTRY_W-1:0] res;
      res = p;
      res[RS1_LO +: OP_W] = clean_op(p[RS1_LO +: OP_W]);
      res[RS2_LO +: OP_W] = clean_op(p[RS2_LO +: OP_W]);
      return res;
   endfunction

   assign issue  = {bus.complex_1_issue, bus.complex_0_issue};
   assign free   = ~valid_reg | issue;
   assign remain = valid_reg & ~issue;
   assign target = ~free[0];

   assign bus.dispatch_ready = free[0] | free[1];
   assign accept             = bus.dispatch_valid & bus.dispatch_ready;

   assign disp_pkt = wake_pkt(clean_pkt(bus.dispatch_inst),
                              bus.wb0_valid, bus.wb0_rob_num, bus.wb0_data,
                              bus.wb1_valid, bus.wb1_rob_num, bus.wb1_data);

   // Dispatch wins over issue of the same slot; an issued or empty slot reads zero.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
         assign hit[gi]        = accept && (target == 1'(gi));
         assign valid_next[gi] = hit[gi] | remain[gi];
         assign pkt_next[gi]   = hit[gi]    ? disp_pkt :
                                 remain[gi] ? wake_pkt(pkt_reg[gi],
                                                       bus.wb0_valid, bus.wb0_rob_num, bus.wb0_data,
                                                       bus.wb1_valid, bus.wb1_rob_num, bus.wb1_data) :
                                              '0;
         assign tag_next[gi]   = hit[gi]    ? bus.dispatch_rob_num :
                                 remain[gi] ? tag_reg[gi] : '0;
      end
   endgenerate

   // Selector tracks the newest entry; when one entry frees it falls to the survivor.
   always_comb begin
      selector_next = selector_reg;
      if (accept) begin
         selector_next = target;
      end else if (|(valid_reg & issue) && (remain[0] ^ remain[1])) begin
         selector_next = remain[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         valid_reg    <= '0;
         selector_reg <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            pkt_reg[i] <= '0;
            tag_reg[i] <= '0;
         end
      end else begin
         valid_reg    <= valid_next;
         selector_reg <= selector_next;
         for (int i = 0; i < 2; i++) begin
            pkt_reg[i] <= pkt_next[i];
            tag_reg[i] <= tag_next[i];
         end
      end
   end

   assign bus.rs_complex_0           = pkt_reg[0];
   assign bus.rs_complex_1           = pkt_reg[1];
   assign bus.rs_complex_0_entry_num = tag_reg[0];
   assign bus.rs_complex_1_entry_num = tag_reg[1];
   assign bus.selector               = selector_reg;

endmodule

// File: tb/tb_rs_complex_station.sv
// Cycle-by-cycle vector bench for rs_complex_station with an expected-result queue.
module tb_rs_complex_station;
   logic clk;
   logic rst;

   rs_complex_if bus ();

   rs_complex_station dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rst;
      logic         flush;
      logic         dv;
      logic [113:0] inst;
      logic [3:0]   rob;
      logic         w0v;
      logic [3:0]   w0t;
      logic [31:0]  w0d;
      logic         w1v;
      logic [3:0]   w1t;
      logic [31:0]  w1d;
      logic         i0;
      logic         i1;
      logic         e_rdy;
      logic [113:0] e0;
      logic [113:0] e1;
      logic [3:0]   et0;
      logic [3:0]   et1;
      logic         esel;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [113:0] mk(input logic [4:0] wr, input logic r1, input logic [31:0] v1,
                                       input logic r2, input logic [31:0] v2, input logic [4:0] ctl,
                                       input logic [5:0] aluop, input logic [31:0] md);
      return {md, aluop, ctl, v2, r2, v1, r1, wr};
   endfunction

   function automatic vec_t row(input string name);
      vec_t v;
      v.name = name;
      v.rst = 0; v.flush = 0; v.dv = 0; v.inst = '0; v.rob = '0;
      v.w0v = 0; v.w0t = '0; v.w0d = '0;
      v.w1v = 0; v.w1t = '0; v.w1d = '0;
      v.i0 = 0; v.i1 = 0;
      v.e_rdy = 1; v.e0 = '0; v.e1 = '0; v.et0 = '0; v.et1 = '0; v.esel = 0;
      return v;
   endfunction

   function automatic vec_t ex(input vec_t v, input logic rdy, input logic [113:0] e0,
                               input logic [113:0] e1, input logic [3:0] t0,
                               input logic [3:0] t1, input logic sel);
      vec_t r;
      r = v;
      r.e_rdy = rdy; r.e0 = e0; r.e1 = e1; r.et0 = t0; r.et1 = t1; r.esel = sel;
      return r;
   endfunction

   task automatic chk(input string name, input string what, input logic [113:0] act,
                      input logic [113:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s %s: got %h want %h", name, what, act, req);
      end
   endtask

   task automatic apply(input vec_t v);
      vec_t e;
      rst                  = v.rst;
      bus.flush            = v.flush;
      bus.dispatch_valid   = v.dv;
      bus.dispatch_inst    = v.inst;
      bus.dispatch_rob_num = v.rob;
      bus.wb0_valid        = v.w0v;
      bus.wb0_rob_num      = v.w0t;
      bus.wb0_data         = v.w0d;
      bus.wb1_valid        = v.w1v;
      bus.wb1_rob_num      = v.w1t;
      bus.wb1_data         = v.w1d;
      bus.complex_0_issue  = v.i0;
      bus.complex_1_issue  = v.i1;
      #1;
      chk(v.name, "dispatch_ready", 114'(bus.dispatch_ready), 114'(v.e_rdy));
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.name, "rs_complex_0", bus.rs_complex_0, e.e0);
      chk(e.name, "rs_complex_1", bus.rs_complex_1, e.e1);
      chk(e.name, "entry_num_0", 114'(bus.rs_complex_0_entry_num), 114'(e.et0));
      chk(e.name, "entry_num_1", 114'(bus.rs_complex_1_entry_num), 114'(e.et1));
      chk(e.name, "selector", 114'(bus.selector), 114'(e.esel));
      $display("[TB] %-20s rdy=%0d sel=%0d tag0=%0d tag1=%0d", e.name, v.e_rdy,
               bus.selector, bus.rs_complex_0_entry_num, bus.rs_complex_1_entry_num);
   endtask

   initial begin
      logic [113:0] z, pa, pb, pb_w, pc, pd, pe, pf_raw, pf, pg_raw, pg, pg_a, pg_ac;
      logic [113:0] ph_raw, ph, pj, pj_w;
      vec_t v;

      z      = '0;
      pa     = mk(5'd3,  1, 32'h5,        1, 32'h7,        5'b00001, 6'h2A, 32'h1234);
      pb     = mk(5'd4,  1, 32'h100,      0, 32'h9,        5'b00011, 6'h01, 32'h0);
      pb_w   = mk(5'd4,  1, 32'h100,      1, 32'hDEADBEEF, 5'b00011, 6'h01, 32'h0);
      pc     = mk(5'd7,  1, 32'h21,       1, 32'h22,       5'b10000, 6'h3F, 32'hAAAA5555);
      pd     = mk(5'd9,  1, 32'h1,        1, 32'h2,        5'b00001, 6'h05, 32'h0);
      pe     = mk(5'd10, 1, 32'h55,       1, 32'h66,       5'b01001, 6'h11, 32'h8);
      pf_raw = mk(5'd11, 0, 32'h4,        1, 32'h3,        5'b00001, 6'h12, 32'h0);
      pf     = mk(5'd11, 1, 32'h11,       1, 32'h3,        5'b00001, 6'h12, 32'h0);
      pg_raw = mk(5'd12, 0, 32'hABCD0002, 0, 32'hFFFF000D, 5'b00101, 6'h20, 32'h99);
      pg     = mk(5'd12, 0, 32'h2,        0, 32'hD,        5'b00101, 6'h20, 32'h99);
      pg_a   = mk(5'd12, 1, 32'hA,        0, 32'hD,        5'b00101, 6'h20, 32'h99);
      pg_ac  = mk(5'd12, 1, 32'hA,        1, 32'hCAFE,     5'b00101, 6'h20, 32'h99);
      ph_raw = mk(5'd13, 0, 32'h1234000E, 1, 32'h44,       5'b00001, 6'h07, 32'h0);
      ph     = mk(5'd13, 0, 32'hE,        1, 32'h44,       5'b00001, 6'h07, 32'h0);
      pj     = mk(5'd14, 1, 32'h9,        0, 32'h5,        5'b00001, 6'h09, 32'h0);
      pj_w   = mk(5'd14, 1, 32'h9,        1, 32'h5A5A,     5'b00001, 6'h09, 32'h0);

      // Stimulus table: each row is one cycle, expected outputs after that edge.
      v = row("reset_state");                                            vecs.push_back(ex(v, 1, z, z, 0, 0, 0));
      v = row("disp_ready_ops");   v.dv = 1; v.inst = pa; v.rob = 3;     vecs.push_back(ex(v, 1, pa, z, 3, 0, 0));
      v = row("issue0");           v.i0 = 1;                             vecs.push_back(ex(v, 1, z, z, 0, 0, 0));
      v = row("disp_wait9");       v.dv = 1; v.inst = pb; v.rob = 6;     vecs.push_back(ex(v, 1, pb, z, 6, 0, 0));
      v = row("disp_slot1");       v.dv = 1; v.inst = pc; v.rob = 7;     vecs.push_back(ex(v, 1, pb, pc, 6, 7, 1));
      v = row("wb1_wake9");        v.w1v = 1; v.w1t = 9; v.w1d = 32'hDEADBEEF;
                                                                         vecs.push_back(ex(v, 0, pb_w, pc, 6, 7, 1));
      v = row("full_drop");        v.dv = 1; v.inst = pd; v.rob = 8;     vecs.push_back(ex(v, 0, pb_w, pc, 6, 7, 1));
      v = row("issue0_disp5");     v.dv = 1; v.inst = pe; v.rob = 5; v.i0 = 1;
                                                                         vecs.push_back(ex(v, 1, pe, pc, 5, 7, 0));
      v = row("issue0_sel_remain"); v.i0 = 1;                            vecs.push_back(ex(v, 1, z, pc, 0, 7, 1));
      v = row("bypass_wb0");       v.dv = 1; v.inst = pf_raw; v.rob = 10;
                                   v.w0v = 1; v.w0t = 4; v.w0d = 32'h11; v.w1v = 1; v.w1t = 12; v.w1d = 32'h99;
                                                                         vecs.push_back(ex(v, 1, pf, pc, 10, 7, 0));
      v = row("issue_both");       v.i0 = 1; v.i1 = 1;                   vecs.push_back(ex(v, 1, z, z, 0, 0, 0));
      v = row("disp_clean_wait");  v.dv = 1; v.inst = pg_raw; v.rob = 11;
                                                                         vecs.push_back(ex(v, 1, pg, z, 11, 0, 0));
      v = row("wb_both_tag2");     v.w0v = 1; v.w0t = 2; v.w0d = 32'hA; v.w1v = 1; v.w1t = 2; v.w1d = 32'hB;
                                                                         vecs.push_back(ex(v, 1, pg_a, z, 11, 0, 0));
      v = row("no_overwrite");     v.w0v = 1; v.w0t = 2; v.w0d = 32'hFF; v.w1v = 1; v.w1t = 13; v.w1d = 32'hCAFE;
                                                                         vecs.push_back(ex(v, 1, pg_ac, z, 11, 0, 0));
      v = row("disp_slot1_wait");  v.dv = 1; v.inst = ph_raw; v.rob = 12;
                                                                         vecs.push_back(ex(v, 1, pg_ac, ph, 11, 12, 1));
      v = row("issue1_ignore_wb"); v.i1 = 1; v.w0v = 1; v.w0t = 14; v.w0d = 32'h77;
                                                                         vecs.push_back(ex(v, 1, pg_ac, z, 11, 0, 0));
      v = row("redisp_slot1");     v.dv = 1; v.inst = ph_raw; v.rob = 12;
                                                                         vecs.push_back(ex(v, 1, pg_ac, ph, 11, 12, 1));
      v = row("flush_disp");       v.flush = 1; v.dv = 1; v.inst = pa; v.rob = 3; v.i0 = 1;
                                                                         vecs.push_back(ex(v, 1, z, z, 0, 0, 0));
      v = row("disp_after_flush"); v.dv = 1; v.inst = pg_raw; v.rob = 11;
                                                                         vecs.push_back(ex(v, 1, pg, z, 11, 0, 0));
      v = row("disp_second");      v.dv = 1; v.inst = ph_raw; v.rob = 12;
                                                                         vecs.push_back(ex(v, 1, pg, ph, 11, 12, 1));
      v = row("rst_mid_wake");     v.rst = 1; v.w0v = 1; v.w0t = 2; v.w0d = 32'h5; v.w1v = 1; v.w1t = 14; v.w1d = 32'h6;
                                                                         vecs.push_back(ex(v, 0, z, z, 0, 0, 0));
      v = row("idle_after_rst");                                         vecs.push_back(ex(v, 1, z, z, 0, 0, 0));

      rst = 1;
      bus.flush = 0; bus.dispatch_valid = 0; bus.dispatch_inst = '0; bus.dispatch_rob_num = '0;
      bus.wb0_valid = 0; bus.wb0_rob_num = '0; bus.wb0_data = '0;
      bus.wb1_valid = 0; bus.wb1_rob_num = '0; bus.wb1_data = '0;
      bus.complex_0_issue = 0; bus.complex_1_issue = 0;
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) apply(vecs[i]);

      // Late wakeup after several idle cycles, full 4-bit tag compare, selector hold at 1.
      v = row("late_disp");        v.dv = 1; v.inst = pj; v.rob = 2;     apply(ex(v, 1, pj, z, 2, 0, 0));
      for (int k = 0; k < 3; k++) begin
         v = row("late_wait");     v.w0v = 1; v.w0t = 4'hD; v.w0d = 32'hBAD;
         apply(ex(v, 1, pj, z, 2, 0, 0));
      end
      v = row("late_wake");        v.w1v = 1; v.w1t = 5; v.w1d = 32'h5A5A;
                                                                         apply(ex(v, 1, pj_w, z, 2, 0, 0));
      v = row("late_slot1");       v.dv = 1; v.inst = pc; v.rob = 7;     apply(ex(v, 1, pj_w, pc, 2, 7, 1));
      v = row("issue_both_hold");  v.i0 = 1; v.i1 = 1;                   apply(ex(v, 1, z, z, 0, 0, 1));
      v = row("empty_hold");                                             apply(ex(v, 1, z, z, 0, 0, 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
